// File: rtl/ram_pkg.sv
// Shared constants and port-operation decode for the dual-port RAM.
package ram_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 6;
    localparam int DEPTH          = 1 << ADDR_WIDTH_DEF;

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_READ,
        PORT_WRITE
    } port_op_e;

    function automatic port_op_e decode_op(input logic cs, input logic we);
        if (!cs) return PORT_IDLE;
        return we ? PORT_WRITE : PORT_READ;
    endfunction
endpackage

// File: rtl/dual_port_ram_if.sv
// Control and registered read-data bundle for one RAM port.
interface dual_port_ram_if #(
    parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH_DEF
);
    logic                  cs;
    logic                  we;
    logic                  oe;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (output cs, we, oe, addr, input data_out);
    modport slave  (input cs, we, oe, addr, output data_out);
endinterface

// File: rtl/ram_port.sv
// One RAM port: read register, read/write decode and bus tri-state driver.
module ram_port
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dual_port_ram_if.slave        bus,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] rd_word,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data
);
    port_op_e              op;
    logic [DATA_WIDTH-1:0] rd_d, rd_q;
    logic                  drive_en;

    always_comb begin
        op    = decode_op(bus.cs, bus.we);
        rd_d  = rd_q;
        wr_en = 1'b0;
        case (op)
            PORT_READ:  rd_d  = rd_word;
            PORT_WRITE: wr_en = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= rd_d;
    end

    // Never drive during a write, whatever oe says, so the master owns the bus.
    assign drive_en     = (op == PORT_READ) && bus.oe;
    assign data         = drive_en ? rd_q : 'z;
    assign wr_data      = data;
    assign bus.data_out = rd_q;
endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM: shared array, read-first across ports, port A wins write collisions.
module dual_port_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_a,
    input  logic                  we_a,
    input  logic                  oe_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    inout  wire  [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_a_out,
    input  logic                  cs_b,
    input  logic                  we_b,
    input  logic                  oe_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    inout  wire  [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] data_b_out
);
    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b, wr_data_a, wr_data_b;
    logic                  wr_en_a, wr_en_b, wr_b_ok;

    dual_port_ram_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) a_if ();
    dual_port_ram_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) b_if ();

    assign a_if.cs   = cs_a;
    assign a_if.we   = we_a;
    assign a_if.oe   = oe_a;
    assign a_if.addr = addr_a;
    assign b_if.cs   = cs_b;
    assign b_if.we   = we_b;
    assign b_if.oe   = oe_b;
    assign b_if.addr = addr_b;
    assign data_a_out = a_if.data_out;
    assign data_b_out = b_if.data_out;

    ram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if), .data(data_a),
        .rd_word(rd_word_a), .wr_en(wr_en_a), .wr_data(wr_data_a)
    );

    ram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if), .data(data_b),
        .rd_word(rd_word_b), .wr_en(wr_en_b), .wr_data(wr_data_b)
    );

    // Reads see pre-edge contents, which gives read-first behaviour across ports.
    always_comb begin
        rd_word_a = mem_q[addr_a];
        rd_word_b = mem_q[addr_b];
        wr_b_ok   = wr_en_b && !(wr_en_a && (addr_a == addr_b));
    end

    always_ff @(posedge clk) begin
        if (wr_en_a) mem_q[addr_a] <= wr_data_a;
        if (wr_b_ok) mem_q[addr_b] <= wr_data_b;
    end
endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram with a read-data scoreboard per port.
module tb_dual_port_ram;
    import ram_pkg::*;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int N  = DEPTH;

    typedef struct {
        logic [DW-1:0] val;
        int            bus;   // 0: no bus check, 1: bus carries val, 2: bus high-Z
        string         nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ia ();
    dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ib ();

    wire  [DW-1:0] data_a, data_b;
    logic          a_drv = 1'b0, b_drv = 1'b0;
    logic [DW-1:0] a_wd = '0, b_wd = '0;
    assign data_a = a_drv ? a_wd : 'z;
    assign data_b = b_drv ? b_wd : 'z;

    dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cs_a(ia.cs), .we_a(ia.we), .oe_a(ia.oe), .addr_a(ia.addr),
        .data_a(data_a), .data_a_out(ia.data_out),
        .cs_b(ib.cs), .we_b(ib.we), .oe_b(ib.oe), .addr_b(ib.addr),
        .data_b(data_b), .data_b_out(ib.data_out)
    );

    exp_t          qa[$], qb[$];
    int            checks = 0, failures = 0;
    logic [DW-1:0] model [N];

    function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endfunction

    function automatic void chkz(string nm, bit is_z);
        checks++;
        if (!is_z) begin
            failures++;
            $display("FAIL %s actual=driven required=high-Z", nm);
        end
    endfunction

    // Monitors: a read sampled at an edge is checked 1 time unit later.
    bit a_iss, b_iss;
    always begin
        exp_t e;
        @(posedge clk);
        a_iss = rst_n && ia.cs && !ia.we;
        #1;
        if (a_iss) begin
            if (qa.size() == 0) chk("a_sb_underflow", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk(e.nm, ia.data_out, e.val);
                if (e.bus == 1) chk({e.nm, "_bus"}, data_a, e.val);
                if (e.bus == 2) chkz({e.nm, "_busz"}, data_a === 'z);
            end
        end
    end

    always begin
        exp_t e;
        @(posedge clk);
        b_iss = rst_n && ib.cs && !ib.we;
        #1;
        if (b_iss) begin
            if (qb.size() == 0) chk("b_sb_underflow", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk(e.nm, ib.data_out, e.val);
                if (e.bus == 1) chk({e.nm, "_bus"}, data_b, e.val);
                if (e.bus == 2) chkz({e.nm, "_busz"}, data_b === 'z);
            end
        end
    end

    // One clock of stimulus; expectations taken from the model before it is updated.
    task automatic op(input bit acs, awe, aoe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                      input bit bcs, bwe, boe, input logic [AW-1:0] bad, input logic [DW-1:0] bwd,
                      input string nm);
        ia.cs = acs; ia.we = awe; ia.oe = aoe; ia.addr = aad;
        ib.cs = bcs; ib.we = bwe; ib.oe = boe; ib.addr = bad;
        a_drv = acs && awe; a_wd = awd;
        b_drv = bcs && bwe; b_wd = bwd;
        if (acs && !awe) qa.push_back('{model[aad], aoe ? 1 : 2, {nm, "_a"}});
        if (bcs && !bwe) qb.push_back('{model[bad], boe ? 1 : 2, {nm, "_b"}});
        if (bcs && bwe && !(acs && awe && aad == bad)) model[bad] = bwd;
        if (acs && awe) model[aad] = awd;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        op(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, "idle");
    endtask

    logic [DW-1:0] held;

    initial begin
        ia.cs = 0; ia.we = 0; ia.oe = 0; ia.addr = '0;
        ib.cs = 0; ib.we = 0; ib.oe = 0; ib.addr = '0;
        #1;
        chk("rst_a_out", ia.data_out, '0);
        chk("rst_b_out", ib.data_out, '0);
        chkz("rst_a_busz", data_a === 'z);
        chkz("rst_b_busz", data_b === 'z);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle();

        for (int i = 0; i < N; i++)
            op(1, 1, 0, AW'(i), (i == 5) ? 32'h12153524 : $urandom, 0, 0, 0, '0, '0, "fill");
        for (int i = 0; i < N; i++) begin
            op(1, 0, 1, AW'(i), '0, 0, 0, 0, '0, '0, "rb");
            if (i == 5) chk("rb_addr5", ia.data_out, 32'h12153524);
        end

        op(0, 0, 0, '0, '0, 1, 1, 0, 6'd10, 32'hDEADBEEF, "cross_wr");
        op(1, 0, 1, 6'd10, '0, 0, 0, 0, '0, '0, "cross_rd");
        chk("cross_a_out", ia.data_out, 32'hDEADBEEF);

        op(1, 0, 0, 6'd20, '0, 0, 0, 0, '0, '0, "oe0_rd");
        held = ia.data_out;
        op(0, 0, 1, 6'd21, '0, 0, 0, 0, '0, '0, "cs0");
        chk("cs0_hold", ia.data_out, held);
        chkz("cs0_busz", data_a === 'z);
        op(1, 1, 1, 6'd21, 32'h5A5A0F0F, 0, 0, 0, '0, '0, "wr_oe1");
        chk("wr_hold", ia.data_out, held);
        chk("wr_no_contend", data_a, 32'h5A5A0F0F);
        op(1, 0, 1, 6'd21, '0, 0, 0, 0, '0, '0, "wr_oe1_rd");
        chk("wr_oe1_val", ia.data_out, 32'h5A5A0F0F);

        op(1, 1, 0, 6'd3, 32'h11111111, 1, 1, 0, 6'd3, 32'h22222222, "coll_wr");
        op(1, 0, 1, 6'd3, '0, 1, 0, 1, 6'd3, '0, "coll_rd");
        chk("coll_a_out", ia.data_out, 32'h11111111);
        chk("coll_b_out", ib.data_out, 32'h11111111);

        op(1, 1, 0, 6'd7, 32'hAAAA0000, 0, 0, 0, '0, '0, "rf_init");
        op(1, 1, 0, 6'd7, 32'h0000BBBB, 1, 0, 1, 6'd7, '0, "rf_wr");
        chk("rf_old", ib.data_out, 32'hAAAA0000);
        op(0, 0, 0, '0, '0, 1, 0, 1, 6'd7, '0, "rf_next");
        chk("rf_new", ib.data_out, 32'h0000BBBB);

        op(1, 1, 0, 6'd30, 32'hCAFE0030, 1, 1, 0, 6'd31, 32'hBEEF0031, "par_wr");
        op(1, 0, 1, 6'd31, '0, 1, 0, 1, 6'd30, '0, "par_rd");
        chk("par_a_out", ia.data_out, 32'hBEEF0031);
        chk("par_b_out", ib.data_out, 32'hCAFE0030);

        ia.cs = 0; ib.cs = 0; a_drv = 0; b_drv = 0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a_out", ia.data_out, '0);
        chk("mid_rst_b_out", ib.data_out, '0);
        chkz("mid_rst_a_busz", data_a === 'z);
        chkz("mid_rst_b_busz", data_b === 'z);
        @(posedge clk);
        #2 rst_n = 1'b1;
        op(1, 0, 1, 6'd10, '0, 1, 0, 1, 6'd3, '0, "post_rst");
        chk("retain_a", ia.data_out, 32'hDEADBEEF);
        chk("retain_b", ib.data_out, 32'h11111111);

        repeat (3) idle();
        chk("a_sb_drain", 32'(qa.size()), 32'd0);
        chk("b_sb_drain", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
- True dual-port synchronous RAM: two independent ports (A, B) share one storage array on a single clock.
- Each port has a bidirectional data bus plus a dedicated registered read-data output.
- Used as a shared scratch buffer between two bus masters.
- Write data enters on the inout bus; read data leaves on the inout bus (tri-stated when not reading) and on data_x_out.

Parameters:
- DATA_WIDTH, 32, width of each word and of every data port.
- ADDR_WIDTH, 6, address width per port.
- DEPTH, 2**ADDR_WIDTH (64), number of words; addresses 0..DEPTH-1, no out-of-range addresses exist.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- cs_a  input  1  port A chip select
- we_a  input  1  port A write enable (1 = write, 0 = read)
- oe_a  input  1  port A output enable for data_a bus
- addr_a  input  ADDR_WIDTH  port A word address
- data_a  inout  DATA_WIDTH  port A bidirectional data bus
- data_a_out  output  DATA_WIDTH  port A registered read data, never tri-stated
- cs_b, we_b, oe_b, addr_b, data_b, data_b_out  same as port A, for port B

Behaviour:
- Reset (rst_n low, asynchronous): data_a_out and data_b_out clear to 0 immediately; internal read registers cleared.
- Reset does not clear memory contents; contents after power-up are undefined.
- Releasing rst_n takes effect at the next rising clk edge.
- Write, port X: at posedge clk, if cs_x=1 and we_x=1, mem[addr_x] <= value on data_x. The external master drives data_x (oe_x=0).
- Read, port X: at posedge clk, if cs_x=1 and we_x=0, read register <= mem[addr_x]. Latency is one cycle: data valid on data_x_out after the sampling edge.
- Holding a read: if cs_x=0, or if port X performs a write, data_x_out holds its previous value.
- Bus drive: data_x is driven with the read register only while cs_x=1, oe_x=1 and we_x=0 (combinational enable). Otherwise data_x is high-Z.
- Bus contention: the RAM never drives data_x while we_x=1, even if oe_x=1.
- Read-during-write, same port: not applicable, because we selects write or read.
- Cross-port, same address, same cycle, A writes and B reads: B returns the OLD contents (read-first); the new value is visible from the next cycle.
- Both ports write the same address in the same cycle: port A wins; port B's write is discarded.
- Both ports read the same address: both get identical data.
- Ports are otherwise fully independent and may access any addresses concurrently.
- Address wrap: none needed; every ADDR_WIDTH value is a valid word.
- X/Z on data_x during a write is stored as-is. No checking is done.

Decomposition:
- Shared package (ram_pkg): default DATA_WIDTH/ADDR_WIDTH constants and a localparam DEPTH = 1 << ADDR_WIDTH.
- One sub-module is natural: ram_port, instantiated twice. It contains the read register, the read/write decode and the tri-state driver.
- Top level owns the memory array and applies the port-A write priority.

Test Plan:
- Reset: assert rst_n=0 mid-simulation after reads -> data_a_out=data_b_out=0 immediately, data_a/data_b high-Z.
- Fill and readback, port A: write random words to addresses 0..63 (cs_a=1, we_a=1, oe_a=0, bench drives data_a). Then read 0..63 (we_a=0, oe_a=1). Required: each word appears on data_a_out and on data_a one cycle after its address; e.g. addr 5 written 0x12153524 reads back 0x12153524.
- Cross-port: write 0xDEADBEEF to addr 10 via port B, then read addr 10 via port A -> data_a_out=0xDEADBEEF next cycle.
- Tri-state: read with oe_a=0 -> data_a high-Z while data_a_out still updates. Set cs_a=0 -> data_a_out holds and the bus stays high-Z.
- Collision: same cycle, A writes 0x11111111 and B writes 0x22222222 to addr 3 -> later read of addr 3 = 0x11111111.
- Read-first: addr 7 holds 0xAAAA0000; A writes 0x0000BBBB to addr 7 while B reads addr 7 -> data_b_out=0xAAAA0000, then a next-cycle read returns 0x0000BBBB.
